instruction_packer: RTL and testbench

INSTRUCTION_PACKER -- requirements
Module: instruction_packer

---
 rtl/instruction_packer.sv | 122 ++++++++++++
 tb/tb_instruction_packer.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_packer.sv
// Packs 32-bit instruction words into 2- or 3-word bundles for a downstream
// instruction-RAM writer, tracking RAM occupancy and emitted bundle count.
module instruction_packer #(
  parameter logic [31:0] NOP_WORD = 32'h0000_0013,
  parameter int unsigned DEPTH    = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_word,
  input  logic         in_last,
  input  logic         flush,
  output logic         write_enable,
  output logic [191:0] instructions,
  output logic [2:0]   quantity,
  output logic         mem_full,
  output logic [15:0]  bundle_count
);

  typedef enum logic {FILL, EMIT} state_e;

  localparam logic [10:0] FULL_THRESHOLD = 11'(DEPTH - 3);

  state_e          state_q;
  logic [1:0]      count_q;
  logic [2:0][31:0] slot_q, slot_d;
  logic            write_enable_q;
  logic [191:0]    instructions_q, instructions_d;
  logic [2:0]      quantity_q, quantity_d;
  logic [15:0]     bundle_count_q;
  logic [10:0]     word_total_q, word_total_d;
  logic            mem_full_q;

  logic            accept;
  logic [2:0]      count_ext;
  logic            go_emit;

  assign in_ready = (state_q == FILL) && !mem_full_q;
  assign accept   = in_valid && in_ready;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    slot_d     = slot_q;
    go_emit    = 1'b0;
    quantity_d = 3'd2;
    count_ext  = {1'b0, count_q} + {2'b00, accept};

    if (accept) begin
      case (count_q)
        2'd0:    slot_d[0] = in_word;
        2'd1:    slot_d[1] = in_word;
        default: slot_d[2] = in_word;
      endcase
    end

    // A word accepted this cycle counts before flush is considered.
    if (state_q == FILL) begin
      if (count_ext == 3'd3) begin
        go_emit    = 1'b1;
        quantity_d = 3'd3;
      end else if (accept && in_last && count_ext == 3'd2) begin
        go_emit = 1'b1;
      end else if (flush && count_ext == 3'd2) begin
        go_emit = 1'b1;
      end else if (flush && count_ext == 3'd1) begin
        go_emit   = 1'b1;
        slot_d[1] = NOP_WORD;
      end
    end

    instructions_d = (quantity_d == 3'd3) ? {96'b0, slot_d}
                                          : {128'b0, slot_d[1], slot_d[0]};
    word_total_d   = word_total_q + 11'(quantity_d);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= FILL;
      count_q        <= 2'd0;
      slot_q         <= '0;
      write_enable_q <= 1'b0;
      instructions_q <= '0;
      quantity_q     <= 3'd0;
      bundle_count_q <= 16'd0;
      word_total_q   <= 11'd0;
      mem_full_q     <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (go_emit) begin
            state_q        <= EMIT;
            write_enable_q <= 1'b1;
            instructions_q <= instructions_d;
            quantity_q     <= quantity_d;
            bundle_count_q <= bundle_count_q + 16'd1;
            word_total_q   <= word_total_d;
            mem_full_q     <= mem_full_q || (word_total_d > FULL_THRESHOLD);
          end
          slot_q  <= slot_d;
          count_q <= count_ext[1:0];
        end
        default: begin
          state_q        <= FILL;
          write_enable_q <= 1'b0;
          count_q        <= 2'd0;
          slot_q         <= '0;
        end
      endcase
    end
  end

  assign write_enable = write_enable_q;
  assign instructions = instructions_q;
  assign quantity     = quantity_q;
  assign mem_full     = mem_full_q;
  assign bundle_count = bundle_count_q;

endmodule

// File: tb/tb_instruction_packer.sv
// Directed bench for instruction_packer: bundling, flush padding, reset
// during EMIT, and RAM-full behaviour on a second DEPTH=8 instance.
module tb_instruction_packer;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic         clk = 1'b0;
  logic         rst, rst8;
  logic         in_valid, in_last, flush;
  logic [31:0]  in_word;

  logic         in_ready, write_enable, mem_full;
  logic [191:0] instructions;
  logic [2:0]   quantity;
  logic [15:0]  bundle_count;

  logic         in_ready8, write_enable8, mem_full8;
  logic [191:0] instructions8;
  logic [2:0]   quantity8;
  logic [15:0]  bundle_count8;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  instruction_packer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_word(in_word), .in_last(in_last), .flush(flush),
    .write_enable(write_enable), .instructions(instructions),
    .quantity(quantity), .mem_full(mem_full), .bundle_count(bundle_count)
  );

  instruction_packer #(.DEPTH(8)) dut8 (
    .clk(clk), .rst(rst8), .in_valid(in_valid), .in_ready(in_ready8),
    .in_word(in_word), .in_last(in_last), .flush(flush),
    .write_enable(write_enable8), .instructions(instructions8),
    .quantity(quantity8), .mem_full(mem_full8), .bundle_count(bundle_count8)
  );

  task automatic check(input string tag, input logic [191:0] got,
                       input logic [191:0] exp);
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] w, input logic last, input logic fl);
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    flush    = fl;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    logic we_seen;
    rst = 1'b1; rst8 = 1'b1;
    in_valid = 1'b0; in_last = 1'b0; flush = 1'b0; in_word = '0;
    tick(); tick();
    check("rst_we",    {191'b0, write_enable}, 192'd0);
    check("rst_instr", instructions, 192'd0);
    check("rst_qty",   {189'b0, quantity}, 192'd0);
    check("rst_bcnt",  {176'b0, bundle_count}, 192'd0);
    check("rst_full",  {191'b0, mem_full}, 192'd0);
    rst = 1'b0;
    check("rst_ready", {191'b0, in_ready}, 192'd1);

    // Two-word group closed by in_last
    push(32'hAAAA_0001, 1'b0, 1'b0);
    check("g2_no_we_a", {191'b0, write_enable}, 192'd0);
    push(32'hBBBB_0002, 1'b1, 1'b0);
    check("g2_we",    {191'b0, write_enable}, 192'd1);
    check("g2_qty",   {189'b0, quantity}, 192'd2);
    check("g2_instr", instructions, {128'b0, 32'hBBBB_0002, 32'hAAAA_0001});
    tick();
    check("g2_we_off", {191'b0, write_enable}, 192'd0);
    check("g2_hold",   instructions, {128'b0, 32'hBBBB_0002, 32'hAAAA_0001});
    check("g2_bcnt",   {176'b0, bundle_count}, 192'd1);

    // Three words, no in_last
    push(32'h1000_0001, 1'b0, 1'b0);
    push(32'h2000_0002, 1'b0, 1'b0);
    push(32'h3000_0003, 1'b0, 1'b0);
    check("g3_we",    {191'b0, write_enable}, 192'd1);
    check("g3_qty",   {189'b0, quantity}, 192'd3);
    check("g3_instr", instructions,
          {96'b0, 32'h3000_0003, 32'h2000_0002, 32'h1000_0001});
    check("g3_ready_emit", {191'b0, in_ready}, 192'd0);
    tick();
    check("g3_ready_back", {191'b0, in_ready}, 192'd1);

    // Single-word group stays buffered and merges with the next group
    push(32'hC0DE_000A, 1'b1, 1'b0);
    check("merge_no_we_a", {191'b0, write_enable}, 192'd0);
    tick();
    check("merge_no_we_idle", {191'b0, write_enable}, 192'd0);
    push(32'hC0DE_000B, 1'b0, 1'b0);
    push(32'hC0DE_000C, 1'b1, 1'b0);
    check("merge_we",    {191'b0, write_enable}, 192'd1);
    check("merge_qty",   {189'b0, quantity}, 192'd3);
    check("merge_instr", instructions,
          {96'b0, 32'hC0DE_000C, 32'hC0DE_000B, 32'hC0DE_000A});
    tick();

    // Flush with one buffered word pads with NOP
    push(32'hF00D_0001, 1'b0, 1'b0);
    do_flush();
    check("fl1_we",    {191'b0, write_enable}, 192'd1);
    check("fl1_qty",   {189'b0, quantity}, 192'd2);
    check("fl1_instr", instructions, {128'b0, NOP, 32'hF00D_0001});
    tick();
    do_flush();
    check("fl0_no_we", {191'b0, write_enable}, 192'd0);
    tick();
    check("fl0_no_we_late", {191'b0, write_enable}, 192'd0);

    // Flush together with an accepted word: word counts first
    push(32'hD00D_0001, 1'b0, 1'b0);
    push(32'hD00D_0002, 1'b0, 1'b1);
    check("flacc_we",    {191'b0, write_enable}, 192'd1);
    check("flacc_instr", instructions, {128'b0, 32'hD00D_0002, 32'hD00D_0001});
    tick();

    // Flush during EMIT is dropped, not remembered
    push(32'hE000_0001, 1'b0, 1'b0);
    push(32'hE000_0002, 1'b1, 1'b0);
    check("emfl_we", {191'b0, write_enable}, 192'd1);
    do_flush();
    push(32'hE000_0003, 1'b0, 1'b0);
    check("emfl_no_we", {191'b0, write_enable}, 192'd0);
    do_flush();
    check("emfl_pad", instructions, {128'b0, NOP, 32'hE000_0003});
    check("bcnt_7",   {176'b0, bundle_count}, 192'd7);
    tick();

    // Reset during the EMIT cycle
    push(32'h5555_0001, 1'b0, 1'b0);
    push(32'h5555_0002, 1'b1, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rstem_we",    {191'b0, write_enable}, 192'd0);
    check("rstem_bcnt",  {176'b0, bundle_count}, 192'd0);
    check("rstem_instr", instructions, 192'd0);
    check("rstem_ready", {191'b0, in_ready}, 192'd1);
    tick();
    check("rstem_we_late", {191'b0, write_enable}, 192'd0);

    // RAM-full on the DEPTH=8 instance
    rst8 = 1'b0;
    check("m8_ready0", {191'b0, in_ready8}, 192'd1);
    push(32'h8000_0001, 1'b0, 1'b0);
    push(32'h8000_0002, 1'b0, 1'b0);
    push(32'h8000_0003, 1'b0, 1'b0);
    check("m8_b1_we",   {191'b0, write_enable8}, 192'd1);
    check("m8_b1_full", {191'b0, mem_full8}, 192'd0);
    tick();
    check("m8_ready1", {191'b0, in_ready8}, 192'd1);
    push(32'h8000_0004, 1'b0, 1'b0);
    push(32'h8000_0005, 1'b0, 1'b0);
    push(32'h8000_0006, 1'b0, 1'b0);
    check("m8_b2_we",   {191'b0, write_enable8}, 192'd1);
    check("m8_b2_full", {191'b0, mem_full8}, 192'd1);
    tick();
    check("m8_ready_full", {191'b0, in_ready8}, 192'd0);
    we_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(32'h8000_0007 + 32'(i), 1'b0, 1'b0);
      we_seen = we_seen | write_enable8;
    end
    repeat (2) begin
      tick();
      we_seen = we_seen | write_enable8;
    end
    check("m8_no_b3",       {191'b0, we_seen}, 192'd0);
    check("m8_ready_stuck", {191'b0, in_ready8}, 192'd0);
    check("m8_full_sticky", {191'b0, mem_full8}, 192'd1);
    check("m8_bcnt",        {176'b0, bundle_count8}, 192'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_compared, n_mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule
